// File: rtl/dadda_mac.sv
// Pipelined signed 16x16 multiply-accumulate around a combinational multiplier.
// Optional per-step saturation with a sticky overflow flag: define DADDA_MAC_SAT_EN.

module dadda16x16 (
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [31:0] OUTT
);
    logic [31:0] row, sum_v, carry_v, tmp_v;

    // Baugh-Wooley rows (cross terms with exactly one sign bit inverted, plus the
    // 2^16 and 2^31 correction bits), folded through a chain of 3:2 compressors.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' and assigns every variable first to avoid latches.
        sum_v   = 32'h8001_0000;
        carry_v = '0;
        row     = '0;
        tmp_v   = '0;
        for (int j = 0; j < 16; j++) begin
            row = '0;
            for (int i = 0; i < 16; i++) begin
                row[i+j] = ((i == 15) != (j == 15)) ? ~(A[i] & B[j]) : (A[i] & B[j]);
            end
            tmp_v   = sum_v ^ carry_v ^ row;
            carry_v = ((sum_v & carry_v) | (sum_v & row) | (carry_v & row)) << 1;
            sum_v   = tmp_v;
        end
        OUTT = sum_v + carry_v;
    end
endmodule

module dadda_mac #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);
    logic                    stall;
    logic                    s1_valid_q, s1_last_q;
    logic [15:0]             s1_a_q, s1_b_q;
    logic [31:0]             prod;
    logic                    s2_valid_q, s2_last_q;
    logic signed [31:0]      s2_prod_q;
    logic signed [ACC_W-1:0] acc_q, acc_d, base, prod_ext;
    logic signed [ACC_W:0]   sum_wide;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    first_q;
    logic                    res_valid_q;
    logic [ACC_W-1:0]        res_acc_q;
    logic [CNT_W-1:0]        res_cnt_q;
`ifdef DADDA_MAC_SAT_EN
    logic                    ovf_q, ovf_d, res_ovf_q;
`endif

    assign stall     = res_valid_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = res_valid_q;
    assign out_acc   = res_acc_q;
    assign out_count = res_cnt_q;

    dadda16x16 u_mul (.A(s1_a_q), .B(s1_b_q), .OUTT(prod));

    always_comb begin
        prod_ext = ACC_W'(s2_prod_q);
        base     = first_q ? '0 : acc_q;
        sum_wide = (ACC_W+1)'(base) + (ACC_W+1)'(prod_ext);
        acc_d    = sum_wide[ACC_W-1:0];
`ifdef DADDA_MAC_SAT_EN
        ovf_d = 1'b0;
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            ovf_d = 1'b1;
            acc_d = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        if (!first_q) ovf_d = ovf_d | ovf_q;
`endif
        if (first_q)     cnt_d = CNT_W'(1);
        else if (&cnt_q) cnt_d = cnt_q;
        else             cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_prod_q   <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b1;
            res_valid_q <= 1'b0;
            res_acc_q   <= '0;
            res_cnt_q   <= '0;
`ifdef DADDA_MAC_SAT_EN
            ovf_q       <= 1'b0;
            res_ovf_q   <= 1'b0;
`endif
        end else if (!stall) begin
            s1_valid_q <= in_valid;
            s1_last_q  <= in_last;
            if (in_valid) begin
                s1_a_q <= in_a;
                s1_b_q <= in_b;
            end
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            if (s1_valid_q) s2_prod_q <= prod;
            // Without a stall any held result is being taken this edge, so valid follows S2.
            res_valid_q <= s2_valid_q & s2_last_q;
            if (s2_valid_q) begin
                acc_q   <= acc_d;
                cnt_q   <= cnt_d;
                first_q <= s2_last_q;
`ifdef DADDA_MAC_SAT_EN
                ovf_q   <= ovf_d;
`endif
                if (s2_last_q) begin
                    res_acc_q <= acc_d;
                    res_cnt_q <= cnt_d;
`ifdef DADDA_MAC_SAT_EN
                    res_ovf_q <= ovf_d;
`endif
                end
            end
        end
    end

`ifdef DADDA_MAC_SAT_EN
    assign out_ovf = res_ovf_q;
`else
    assign out_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_dadda_mac.sv
// Randomized and directed bench for dadda_mac; runs a 40-bit and a 32-bit accumulator side by side.

module tb_dadda_mac;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_last, out_ready;
    logic [15:0] in_a, in_b;
    logic        in_ready, out_valid, out_ovf;
    logic [39:0] out_acc;
    logic [7:0]  out_count;
    logic        in_ready32, out_valid32, out_ovf32;
    logic [31:0] out_acc32;
    logic [7:0]  out_count32;

    always #5 clk = ~clk;

    dadda_mac #(.ACC_W(40), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf));

    dadda_mac #(.ACC_W(32), .CNT_W(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid32),
        .out_ready(out_ready), .out_acc(out_acc32), .out_count(out_count32), .out_ovf(out_ovf32));

    typedef struct {
        longint acc40;
        longint acc32;
        int     cnt;
        bit     ovf40;
        bit     ovf32;
        int     cyc;
    } res_t;

    res_t   exp_q[$];
    res_t   obs_q[$];
    int     errors = 0;
    int     checks = 0;
    int     cycle  = 0;
    longint m_acc40, m_acc32, m_p;
    bit     m_ovf40, m_ovf32, m_o;
    bit     m_first = 1'b1;
    int     m_cnt;

    // Reference arithmetic: clamp (saturating build) or wrap to a w-bit signed value.
    function automatic longint fit(input longint v, input int w, output bit ovf);
        longint hi, lo, m, r;
        hi  = (longint'(1) <<< (w - 1)) - 1;
        lo  = -(longint'(1) <<< (w - 1));
        ovf = 1'b0;
`ifdef DADDA_MAC_SAT_EN
        if (v > hi) begin ovf = 1'b1; return hi; end
        if (v < lo) begin ovf = 1'b1; return lo; end
        return v;
`else
        m = longint'(1) <<< w;
        r = (v - lo) % m;
        if (r < 0) r += m;
        return r + lo;
`endif
    endfunction

    // Model updates on accepted beats; observed results are logged on each output handshake.
    always @(negedge clk) begin
        cycle++;
        if (rst) begin
            m_first = 1'b1;
        end else begin
            if (out_valid && out_ready)
                obs_q.push_back('{longint'($signed(out_acc)), longint'($signed(out_acc32)),
                                  int'(out_count), out_ovf, out_ovf32, cycle});
            if (in_valid && in_ready) begin
                m_p = longint'($signed(in_a)) * longint'($signed(in_b));
                if (m_first) begin
                    m_acc40 = fit(m_p, 40, m_o); m_ovf40 = m_o;
                    m_acc32 = fit(m_p, 32, m_o); m_ovf32 = m_o;
                    m_cnt   = 1;
                end else begin
                    m_acc40 = fit(m_acc40 + m_p, 40, m_o); m_ovf40 = m_ovf40 | m_o;
                    m_acc32 = fit(m_acc32 + m_p, 32, m_o); m_ovf32 = m_ovf32 | m_o;
                    m_cnt   = (m_cnt == 255) ? 255 : m_cnt + 1;
                end
                m_first = in_last;
                if (in_last) exp_q.push_back('{m_acc40, m_acc32, m_cnt, m_ovf40, m_ovf32, cycle});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
        int n = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        @(negedge clk);
        while (!in_ready && n < 100) begin n++; @(negedge clk); end
        checks++;
        if (!in_ready) begin errors++; $display("FAIL send_timeout: in_ready got 0 expected 1"); end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_obs(input int n, output bit ok);
        int t = 0;
        while (obs_q.size() < n && t < 300) begin @(negedge clk); #1; t++; end
        ok = (obs_q.size() >= n);
        checks++;
        if (!ok) begin errors++; $display("FAIL result_timeout: got %0d results expected %0d", obs_q.size(), n); end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (2) tick();
        checks += 6;
        if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid: got %0b expected 0", out_valid); end
        if (in_ready !== 1'b1)   begin errors++; $display("FAIL rst_in_ready: got %0b expected 1", in_ready); end
        if (out_acc !== 40'd0)   begin errors++; $display("FAIL rst_out_acc: got %0d expected 0", out_acc); end
        if (out_count !== 8'd0)  begin errors++; $display("FAIL rst_out_count: got %0d expected 0", out_count); end
        if (out_ovf !== 1'b0)    begin errors++; $display("FAIL rst_out_ovf: got %0b expected 0", out_ovf); end
        if (out_valid32 !== 1'b0) begin errors++; $display("FAIL rst_out_valid32: got %0b expected 0", out_valid32); end
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_single();
        res_t e, o;
        bit   ok;
        exp_q.delete(); obs_q.delete();
        send(16'd3, 16'hFFFC, 1'b1);
        wait_obs(1, ok);
        if (!ok) return;
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks += 4;
        if (o.acc40 != -12) begin errors++; $display("FAIL single_acc: got %0d expected -12", o.acc40); end
        if (o.acc32 != -12) begin errors++; $display("FAIL single_acc32: got %0d expected -12", o.acc32); end
        if (o.cnt != 1)     begin errors++; $display("FAIL single_count: got %0d expected 1", o.cnt); end
        if (o.cyc - e.cyc != 3) begin errors++; $display("FAIL single_latency: got %0d expected 3", o.cyc - e.cyc); end
    endtask

    task automatic test_min_neg();
        res_t e, o;
        bit   ok;
        exp_q.delete(); obs_q.delete();
        for (int k = 0; k < 4; k++) send(16'h8000, 16'h8000, k == 3);
        wait_obs(1, ok);
        if (!ok) return;
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks += 5;
        if (o.acc40 != 64'd4294967296) begin errors++; $display("FAIL minneg_acc: got %0d expected 4294967296", o.acc40); end
        if (o.cnt != 4)      begin errors++; $display("FAIL minneg_count: got %0d expected 4", o.cnt); end
        if (o.ovf40 != 1'b0) begin errors++; $display("FAIL minneg_ovf: got %0b expected 0", o.ovf40); end
        if (o.acc32 != e.acc32) begin errors++; $display("FAIL minneg_acc32: got %0d expected %0d", o.acc32, e.acc32); end
        if (o.ovf32 != e.ovf32) begin errors++; $display("FAIL minneg_ovf32: got %0b expected %0b", o.ovf32, e.ovf32); end
    endtask

    task automatic test_ovf32();
        res_t   o;
        bit     ok;
        longint want;
        bit     want_ovf;
`ifdef DADDA_MAC_SAT_EN
        want = 64'd2147483647; want_ovf = 1'b1;
`else
        want = -64'sd1073741824; want_ovf = 1'b0;
`endif
        exp_q.delete(); obs_q.delete();
        for (int k = 0; k < 3; k++) send(16'h8000, 16'h8000, k == 2);
        wait_obs(1, ok);
        if (!ok) return;
        o = obs_q.pop_front();
        checks += 3;
        if (o.acc32 != want)     begin errors++; $display("FAIL ovf32_acc: got %0d expected %0d", o.acc32, want); end
        if (o.ovf32 != want_ovf) begin errors++; $display("FAIL ovf32_flag: got %0b expected %0b", o.ovf32, want_ovf); end
        if (o.acc40 != 64'd3221225472) begin errors++; $display("FAIL ovf32_acc40: got %0d expected 3221225472", o.acc40); end
    endtask

    task automatic test_backpressure();
        res_t a, b;
        bit   ok;
        int   t = 0;
        exp_q.delete(); obs_q.delete();
        out_ready = 1'b0;
        send(16'd2, 16'd3, 1'b0);
        send(16'd4, 16'd5, 1'b1);
        send(16'd7, 16'd7, 1'b1);
        @(negedge clk);
        while (!out_valid && t < 50) begin t++; @(negedge clk); end
        for (int k = 0; k < 5; k++) begin
            checks += 3;
            if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_in_ready: got %0b expected 0", in_ready); end
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %0b expected 1", out_valid); end
            if (out_acc !== 40'd26) begin errors++; $display("FAIL bp_hold_acc: got %0d expected 26", out_acc); end
            if (k < 4) @(negedge clk);
        end
        tick();
        out_ready = 1'b1;
        wait_obs(2, ok);
        if (!ok) return;
        a = obs_q.pop_front(); b = obs_q.pop_front();
        repeat (4) tick();
        checks += 6;
        if (a.acc40 != 26) begin errors++; $display("FAIL bp_first_acc: got %0d expected 26", a.acc40); end
        if (a.cnt != 2)    begin errors++; $display("FAIL bp_first_count: got %0d expected 2", a.cnt); end
        if (b.acc40 != 49) begin errors++; $display("FAIL bp_second_acc: got %0d expected 49", b.acc40); end
        if (b.cnt != 1)    begin errors++; $display("FAIL bp_second_count: got %0d expected 1", b.cnt); end
        if (b.cyc - a.cyc != 1) begin errors++; $display("FAIL bp_second_gap: got %0d expected 1", b.cyc - a.cyc); end
        if (obs_q.size() != 0)  begin errors++; $display("FAIL bp_extra_results: got %0d expected 0", obs_q.size()); end
    endtask

    task automatic test_reset_mid();
        res_t o;
        bit   ok;
        exp_q.delete(); obs_q.delete();
        send(16'd1, 16'd2, 1'b0);
        send(16'd3, 16'd4, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %0b expected 1", in_ready); end
        tick();
        rst = 1'b0;
        repeat (5) tick();
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL midrst_spurious: got %0d results expected 0", obs_q.size()); end
        send(16'd5, 16'd5, 1'b1);
        wait_obs(1, ok);
        if (!ok) return;
        o = obs_q.pop_front();
        checks += 2;
        if (o.acc40 != 25) begin errors++; $display("FAIL midrst_acc: got %0d expected 25", o.acc40); end
        if (o.cnt != 1)    begin errors++; $display("FAIL midrst_count: got %0d expected 1", o.cnt); end
    endtask

    task automatic test_back_to_back();
        res_t a, b;
        bit   ok;
        int   prev;
        exp_q.delete(); obs_q.delete();
        for (int k = 1; k <= 4; k++) send(16'(k), 16'(k), (k % 2) == 0);
        wait_obs(2, ok);
        if (!ok) return;
        a = obs_q.pop_front(); b = obs_q.pop_front();
        checks += 3;
        if (a.acc40 != 5)  begin errors++; $display("FAIL b2b_pair_first: got %0d expected 5", a.acc40); end
        if (b.acc40 != 25) begin errors++; $display("FAIL b2b_pair_second: got %0d expected 25", b.acc40); end
        if (b.cyc - a.cyc != 2) begin errors++; $display("FAIL b2b_pair_gap: got %0d expected 2", b.cyc - a.cyc); end
        for (int k = 1; k <= 4; k++) send(16'(k + 10), 16'hFFFF, 1'b1);
        wait_obs(4, ok);
        if (!ok) return;
        for (int k = 1; k <= 4; k++) begin
            a = obs_q.pop_front();
            checks++;
            if (a.acc40 != -(k + 10)) begin errors++; $display("FAIL b2b_single_acc: got %0d expected %0d", a.acc40, -(k + 10)); end
            if (k > 1) begin
                checks++;
                if (a.cyc - prev != 1) begin errors++; $display("FAIL b2b_single_gap: got %0d expected 1", a.cyc - prev); end
            end
            prev = a.cyc;
        end
    endtask

    task automatic test_random();
        res_t e, o;
        bit   ok;
        bit   done = 1'b0;
        exp_q.delete(); obs_q.delete();
        fork
            begin
                for (int v = 0; v < 30; v++) begin
                    int len = $urandom_range(1, 6);
                    for (int k = 0; k < len; k++) begin
                        logic [15:0] a, b;
                        a = ($urandom_range(0, 4) == 0) ? 16'h8000 : 16'($urandom);
                        b = ($urandom_range(0, 4) == 0) ? 16'h8000 : 16'($urandom);
                        send(a, b, k == len - 1);
                        if ($urandom_range(0, 3) == 0) tick();
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        wait_obs(exp_q.size(), ok);
        if (!ok) return;
        repeat (4) tick();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_result_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks += 5;
            if (o.acc40 != e.acc40) begin errors++; $display("FAIL rand_acc40: got %0d expected %0d", o.acc40, e.acc40); end
            if (o.acc32 != e.acc32) begin errors++; $display("FAIL rand_acc32: got %0d expected %0d", o.acc32, e.acc32); end
            if (o.cnt != e.cnt)     begin errors++; $display("FAIL rand_count: got %0d expected %0d", o.cnt, e.cnt); end
            if (o.ovf40 != e.ovf40) begin errors++; $display("FAIL rand_ovf40: got %0b expected %0b", o.ovf40, e.ovf40); end
            if (o.ovf32 != e.ovf32) begin errors++; $display("FAIL rand_ovf32: got %0b expected %0b", o.ovf32, e.ovf32); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_min_neg();
        test_ovf32();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
